uidbufw_arbiter_n: RTL and testbench



---
 rtl/uidbufw_arbiter_n_if.sv | 46 ++++
 rtl/uidbufw_arbiter_n.sv | 163 ++++++++++++++++
 tb/tb_uidbufw_arbiter_n.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uidbufw_arbiter_n_if.sv
`default_nettype none
// ============================================================================
// Module   : uidbufw_arbiter_n_if
// Brief    : Bundle of the upstream uidbuf write channels, the downstream FDMA
//            write port and the grant/status outputs of uidbufw_arbiter_n.
// Revision : 1.0 - initial release
// ============================================================================
interface uidbufw_arbiter_n_if #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 21,
  parameter int NUM_CH         = 4
);
  localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH*AXI_ADDR_WIDTH-1:0] ch_waddr;
  logic [NUM_CH-1:0]                ch_wareq;
  logic [NUM_CH*16-1:0]             ch_wsize;
  logic [NUM_CH-1:0]                ch_wbusy;
  logic [NUM_CH*AXI_DATA_WIDTH-1:0] ch_wdata;
  logic [NUM_CH-1:0]                ch_wvalid;
  logic [AXI_ADDR_WIDTH-1:0]        fdma_waddr;
  logic                             fdma_wareq;
  logic [15:0]                      fdma_wsize;
  logic                             fdma_wbusy;
  logic [AXI_DATA_WIDTH-1:0]        fdma_wdata;
  logic                             fdma_wvalid;
  logic [GW-1:0]                    grant_id;
  logic                             grant_act;
  logic                             timeout_err;
  logic [NUM_CH*16-1:0]             grant_cnt;

  // The arbiter's view
  modport master (
    input  ch_waddr, ch_wareq, ch_wsize, ch_wdata, fdma_wbusy, fdma_wvalid,
    output ch_wbusy, ch_wvalid, fdma_waddr, fdma_wareq, fdma_wsize, fdma_wdata,
    output grant_id, grant_act, timeout_err, grant_cnt
  );

  // The surrounding channels and FDMA port
  modport slave (
    output ch_waddr, ch_wareq, ch_wsize, ch_wdata, fdma_wbusy, fdma_wvalid,
    input  ch_wbusy, ch_wvalid, fdma_waddr, fdma_wareq, fdma_wsize, fdma_wdata,
    input  grant_id, grant_act, timeout_err, grant_cnt
  );
endinterface
`default_nettype wire

// File: rtl/uidbufw_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module   : uidbufw_arbiter_n
// Brief    : N-channel round-robin FDMA write arbiter with REQ watchdog.
//            Optional per-channel grant counters: `define UIDBUFW_ARB_STATS_EN
// Revision : 1.0 - initial release
// ============================================================================
module uidbufw_arbiter_n #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 21,
  parameter int NUM_CH         = 4,
  parameter int TIMEOUT_CYC    = 1024
) (
  input  logic                 ui_clk,
  input  logic                 ui_rstn,
  uidbufw_arbiter_n_if.master  bus
);

  localparam int GW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit WD_EN = (TIMEOUT_CYC != 0);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_BUSY = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  logic [1:0]                r_state;
  logic [1:0]                w_next;
  logic [GW-1:0]             r_last_grant;
  logic [GW-1:0]             r_grant_id;
  logic [AXI_ADDR_WIDTH-1:0] r_waddr;
  logic [15:0]               r_wsize;
  logic                      r_wareq;
  logic                      r_grant_act;
  logic                      r_timeout_err;
  logic [CW-1:0]             r_wd_cnt;

  logic                      w_hit;
  logic [GW-1:0]             w_sel;
  logic [GW-1:0]             w_idx;
  logic [AXI_ADDR_WIDTH-1:0] w_sel_addr;
  logic [15:0]               w_sel_size;
  logic                      w_wd_expire;
  logic [NUM_CH-1:0]         w_wbusy;
  logic [NUM_CH-1:0]         w_wvalid;
  logic [AXI_DATA_WIDTH-1:0] w_wdata;

  // Round-robin scan starting one past the last channel that finished
  always_comb begin
    w_hit      = 1'b0;
    w_sel      = '0;
    w_idx      = r_last_grant;
    w_sel_addr = '0;
    w_sel_size = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_idx = (w_idx == GW'(NUM_CH - 1)) ? '0 : w_idx + 1'b1;
      if (!w_hit && bus.ch_wareq[w_idx]) begin
        w_hit = 1'b1;
        w_sel = w_idx;
      end
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_sel == GW'(k)) begin
        w_sel_addr = bus.ch_waddr[k*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        w_sel_size = bus.ch_wsize[k*16 +: 16];
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    w_wd_expire = 1'b0;
    case (r_state)
      ST_IDLE: if (w_hit) w_next = ST_REQ;
      ST_REQ: begin
        if (bus.fdma_wbusy) begin
          w_next = ST_BUSY;
        end else if (WD_EN && (r_wd_cnt == CW'(TIMEOUT_CYC - 1))) begin
          w_next      = ST_IDLE;
          w_wd_expire = 1'b1;
        end
      end
      ST_BUSY: if (!bus.fdma_wbusy) w_next = ST_GAP;
      ST_GAP:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge ui_clk or negedge ui_rstn) begin
    if (!ui_rstn) begin
      r_state       <= ST_IDLE;
      r_last_grant  <= GW'(NUM_CH - 1);
      r_grant_id    <= '0;
      r_waddr       <= '0;
      r_wsize       <= '0;
      r_wareq       <= 1'b0;
      r_grant_act   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_wd_cnt      <= '0;
    end else begin
      r_state       <= w_next;
      r_wareq       <= (w_next == ST_REQ);
      r_grant_act   <= (w_next == ST_REQ) || (w_next == ST_BUSY);
      r_timeout_err <= w_wd_expire;
      if (r_state == ST_IDLE && w_hit) begin
        r_grant_id <= w_sel;
        r_waddr    <= w_sel_addr;
        r_wsize    <= w_sel_size;
      end
      if (r_state != ST_REQ)
        r_wd_cnt <= '0;
      else if (WD_EN)
        r_wd_cnt <= r_wd_cnt + 1'b1;
      // A timed-out channel also moves to the back of the queue
      if ((r_state == ST_BUSY && !bus.fdma_wbusy) || w_wd_expire)
        r_last_grant <= r_grant_id;
    end
  end

  // Strobes only reach the granted channel; data strobe only counts in BUSY
  always_comb begin
    w_wbusy  = '0;
    w_wvalid = '0;
    w_wdata  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (r_grant_act && (r_grant_id == GW'(k))) begin
        w_wbusy[k]  = bus.fdma_wbusy;
        w_wvalid[k] = bus.fdma_wvalid && (r_state == ST_BUSY);
        w_wdata     = bus.ch_wdata[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
      end
    end
  end

  assign bus.ch_wbusy    = w_wbusy;
  assign bus.ch_wvalid   = w_wvalid;
  assign bus.fdma_wdata  = w_wdata;
  assign bus.fdma_waddr  = r_waddr;
  assign bus.fdma_wsize  = r_wsize;
  assign bus.fdma_wareq  = r_wareq;
  assign bus.grant_id    = r_grant_id;
  assign bus.grant_act   = r_grant_act;
  assign bus.timeout_err = r_timeout_err;

`ifdef UIDBUFW_ARB_STATS_EN
  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_stats
      logic [15:0] r_cnt;
      always_ff @(posedge ui_clk or negedge ui_rstn) begin
        if (!ui_rstn)
          r_cnt <= '0;
        else if (r_state == ST_IDLE && w_hit && w_sel == GW'(k) && r_cnt != 16'hFFFF)
          r_cnt <= r_cnt + 1'b1;
      end
      assign bus.grant_cnt[k*16 +: 16] = r_cnt;
    end
  endgenerate
`else
  assign bus.grant_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uidbufw_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_uidbufw_arbiter_n
// Brief    : Directed self-checking bench for uidbufw_arbiter_n (4 channels).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uidbufw_arbiter_n;

  logic ui_clk  = 1'b0;
  logic ui_rstn = 1'b0;
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   fall_cyc = 0;

  always #5 ui_clk = ~ui_clk;
  always @(posedge ui_clk) cyc <= cyc + 1;

  uidbufw_arbiter_n_if #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(21), .NUM_CH(4)) bus ();

  uidbufw_arbiter_n #(
    .AXI_DATA_WIDTH(32),
    .AXI_ADDR_WIDTH(21),
    .NUM_CH        (4),
    .TIMEOUT_CYC   (16)
  ) dut (
    .ui_clk (ui_clk),
    .ui_rstn(ui_rstn),
    .bus    (bus)
  );

  task automatic tick();
    @(posedge ui_clk);
    #1;
  endtask

  task automatic do_reset();
    ui_rstn         = 1'b0;
    bus.ch_waddr    = '0;
    bus.ch_wareq    = '0;
    bus.ch_wsize    = '0;
    bus.ch_wdata    = '0;
    bus.fdma_wbusy  = 1'b0;
    bus.fdma_wvalid = 1'b0;
    repeat (2) @(posedge ui_clk);
    #3;
    ui_rstn = 1'b1;
    tick();
  endtask

  // Downstream FDMA model: accept request, stay busy for 'beats' strobes
  task automatic serve(input int beats, input bit drop, output bit ok, output int gid,
                       output int rise_cyc);
    int n;
    ok = 1'b0; gid = -1; rise_cyc = 0; n = 0;
    while (!ok && n < 50) begin
      if (bus.fdma_wareq === 1'b1) ok = 1'b1;
      else begin tick(); n++; end
    end
    if (ok) begin
      gid            = int'(bus.grant_id);
      rise_cyc       = cyc;
      bus.fdma_wbusy = 1'b1;
      if (drop) bus.ch_wareq = '0;
      tick();
      for (int b = 0; b < beats; b++) begin
        bus.fdma_wvalid = 1'b1;
        tick();
      end
      bus.fdma_wvalid = 1'b0;
      bus.fdma_wbusy  = 1'b0;
      fall_cyc        = cyc;
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (bus.fdma_wareq !== 1'b0) begin n_fail++; $display("FAIL rst_wareq: got %b expected 0", bus.fdma_wareq); end
    n_tests++; if (bus.fdma_waddr !== 21'h0) begin n_fail++; $display("FAIL rst_waddr: got %h expected 0", bus.fdma_waddr); end
    n_tests++; if (bus.fdma_wsize !== 16'h0) begin n_fail++; $display("FAIL rst_wsize: got %h expected 0", bus.fdma_wsize); end
    n_tests++; if (bus.grant_act !== 1'b0) begin n_fail++; $display("FAIL rst_grant_act: got %b expected 0", bus.grant_act); end
    n_tests++; if (bus.grant_id !== 2'd0) begin n_fail++; $display("FAIL rst_grant_id: got %0d expected 0", bus.grant_id); end
    n_tests++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_timeout: got %b expected 0", bus.timeout_err); end
    bus.fdma_wvalid = 1'b1;
    #1;
    n_tests++; if (bus.ch_wvalid !== 4'h0) begin n_fail++; $display("FAIL idle_wvalid_ignored: got %h expected 0", bus.ch_wvalid); end
    n_tests++; if (bus.fdma_wdata !== 32'h0) begin n_fail++; $display("FAIL idle_wdata: got %h expected 0", bus.fdma_wdata); end
    bus.fdma_wvalid = 1'b0;
  endtask

  task automatic test_single();
    int  pulses = 0;
    bit  leak   = 1'b0;
    do_reset();
    bus.ch_waddr[2*21 +: 21] = 21'h1000;
    bus.ch_wsize[2*16 +: 16] = 16'd64;
    bus.ch_wareq[2]          = 1'b1;
    #1;
    n_tests++; if (bus.fdma_wareq !== 1'b0) begin n_fail++; $display("FAIL single_wareq_t0: got %b expected 0", bus.fdma_wareq); end
    tick();
    n_tests++; if (bus.fdma_wareq !== 1'b1) begin n_fail++; $display("FAIL single_wareq_t1: got %b expected 1", bus.fdma_wareq); end
    n_tests++; if (bus.grant_id !== 2'd2) begin n_fail++; $display("FAIL single_grant_id: got %0d expected 2", bus.grant_id); end
    n_tests++; if (bus.fdma_waddr !== 21'h1000) begin n_fail++; $display("FAIL single_waddr: got %h expected 1000", bus.fdma_waddr); end
    n_tests++; if (bus.fdma_wsize !== 16'd64) begin n_fail++; $display("FAIL single_wsize: got %0d expected 64", bus.fdma_wsize); end
    bus.fdma_wbusy = 1'b1;
    #1;
    n_tests++; if (bus.ch_wbusy !== 4'b0100) begin n_fail++; $display("FAIL single_ch_wbusy: got %b expected 0100", bus.ch_wbusy); end
    bus.ch_wareq = '0;
    tick();
    n_tests++; if (bus.fdma_wareq !== 1'b0) begin n_fail++; $display("FAIL single_wareq_busy: got %b expected 0", bus.fdma_wareq); end
    for (int b = 0; b < 64; b++) begin
      bus.fdma_wvalid = 1'b1;
      #1;
      if (bus.ch_wvalid[2] === 1'b1) pulses++;
      if ((bus.ch_wbusy & 4'b1011) !== 4'b0000 || (bus.ch_wvalid & 4'b1011) !== 4'b0000) leak = 1'b1;
      tick();
    end
    bus.fdma_wvalid = 1'b0;
    bus.fdma_wbusy  = 1'b0;
    tick();
    n_tests++; if (pulses !== 64) begin n_fail++; $display("FAIL single_pulses: got %0d expected 64", pulses); end
    n_tests++; if (leak !== 1'b0) begin n_fail++; $display("FAIL single_other_ch: got %b expected 0", leak); end
    n_tests++; if (bus.grant_act !== 1'b0) begin n_fail++; $display("FAIL single_gap_act: got %b expected 0", bus.grant_act); end
  endtask

  task automatic test_round_robin();
    int exp_order [5] = '{0, 1, 2, 3, 0};
    bit ok; int gid; int rise; int prev_fall;
    do_reset();
    bus.ch_wareq = 4'hF;
    for (int i = 0; i < 5; i++) begin
      prev_fall = fall_cyc;
      serve(4, 1'b0, ok, gid, rise);
      n_tests++; if (!ok || gid !== exp_order[i]) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d expected %0d (ok=%b)", i, gid, exp_order[i], ok); end
      if (i > 0) begin
        n_tests++; if (rise - prev_fall < 2) begin n_fail++; $display("FAIL rr_spacing[%0d]: got %0d cycles expected >=2", i, rise - prev_fall); end
      end
    end
  endtask

  task automatic test_data_align();
    bit ok = 1'b0; int n = 0; bit exp_v; int bad = 0; int seen = 0;
    do_reset();
    bus.ch_wdata = {32'hDEAD0003, 32'hDEAD0002, 32'hA5A50001, 32'hDEAD0000};
    bus.ch_wareq[1] = 1'b1;
    while (!ok && n < 20) begin
      if (bus.fdma_wareq === 1'b1) ok = 1'b1; else begin tick(); n++; end
    end
    n_tests++; if (!ok || bus.grant_id !== 2'd1) begin n_fail++; $display("FAIL align_grant: got %0d expected 1 (ok=%b)", bus.grant_id, ok); end
    bus.fdma_wbusy = 1'b1;
    bus.ch_wareq   = '0;
    tick();
    for (int i = 0; i < 8; i++) begin
      exp_v = (i % 2 == 0);
      bus.fdma_wvalid = exp_v;
      bus.ch_wdata[1*32 +: 32] = 32'hA5A50001 + i;
      #1;
      if (bus.ch_wvalid[1] !== exp_v) bad++;
      if (bus.ch_wvalid[1] === 1'b1) begin
        seen++;
        if (bus.fdma_wdata !== 32'hA5A50001 + i) bad++;
      end
      tick();
    end
    bus.fdma_wvalid = 1'b0;
    bus.fdma_wbusy  = 1'b0;
    tick();
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL align_data: got %0d bad beats expected 0", bad); end
    n_tests++; if (seen !== 4) begin n_fail++; $display("FAIL align_strobes: got %0d expected 4", seen); end
    n_tests++; if (bus.fdma_wdata !== 32'h0) begin n_fail++; $display("FAIL align_wdata_idle: got %h expected 0", bus.fdma_wdata); end
  endtask

  task automatic test_watchdog();
    int req_cyc = 0; int n = 0; bit hit = 1'b0;
    do_reset();
    bus.ch_wareq[3] = 1'b1;
    tick();
    bus.ch_wareq[0] = 1'b1;
    while (!hit && n < 40) begin
      if (bus.timeout_err === 1'b1) hit = 1'b1;
      else begin
        if (bus.grant_act === 1'b1) req_cyc++;
        tick(); n++;
      end
    end
    n_tests++; if (!hit) begin n_fail++; $display("FAIL wd_expire: got no pulse expected pulse within 40 cycles"); end
    n_tests++; if (req_cyc !== 16) begin n_fail++; $display("FAIL wd_req_cycles: got %0d expected 16", req_cyc); end
    n_tests++; if (bus.grant_act !== 1'b0 || bus.fdma_wareq !== 1'b0) begin n_fail++; $display("FAIL wd_release: got act=%b req=%b expected 0/0", bus.grant_act, bus.fdma_wareq); end
    tick();
    n_tests++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL wd_pulse_width: got %b expected 0", bus.timeout_err); end
    n_tests++; if (bus.fdma_wareq !== 1'b1 || bus.grant_id !== 2'd0) begin n_fail++; $display("FAIL wd_next_grant: got req=%b id=%0d expected 1/0", bus.fdma_wareq, bus.grant_id); end
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    bus.ch_waddr[1*21 +: 21] = 21'h0ABCD;
    bus.ch_wsize[1*16 +: 16] = 16'd8;
    bus.ch_wareq[1] = 1'b1;
    tick();
    bus.fdma_wbusy = 1'b1;
    tick();
    n_tests++; if (bus.grant_act !== 1'b1 || bus.grant_id !== 2'd1) begin n_fail++; $display("FAIL mid_busy_state: got act=%b id=%0d expected 1/1", bus.grant_act, bus.grant_id); end
    #3;
    ui_rstn = 1'b0;
    #1;
    n_tests++; if (bus.fdma_wareq !== 1'b0 || bus.grant_act !== 1'b0 || bus.grant_id !== 2'd0) begin n_fail++; $display("FAIL mid_rst_ctrl: got req=%b act=%b id=%0d expected 0/0/0", bus.fdma_wareq, bus.grant_act, bus.grant_id); end
    n_tests++; if (bus.fdma_waddr !== 21'h0 || bus.fdma_wsize !== 16'h0) begin n_fail++; $display("FAIL mid_rst_addr: got %h/%h expected 0/0", bus.fdma_waddr, bus.fdma_wsize); end
    n_tests++; if (bus.ch_wbusy !== 4'h0) begin n_fail++; $display("FAIL mid_rst_ch_wbusy: got %b expected 0", bus.ch_wbusy); end
    bus.fdma_wbusy = 1'b0;
    #2;
    ui_rstn = 1'b1;
    tick();
    n_tests++; if (bus.fdma_wareq !== 1'b1 || bus.grant_id !== 2'd1) begin n_fail++; $display("FAIL mid_rst_regrant: got req=%b id=%0d expected 1/1", bus.fdma_wareq, bus.grant_id); end
  endtask

  task automatic test_stats();
    int tgt [5] = '{0, 2, 0, 2, 0};
    bit ok; int gid; int rise; int e0; int e2;
`ifdef UIDBUFW_ARB_STATS_EN
    e0 = 3; e2 = 2;
`else
    e0 = 0; e2 = 0;
`endif
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.ch_wareq = 4'(1 << tgt[i]);
      serve(2, 1'b1, ok, gid, rise);
      n_tests++; if (!ok || gid !== tgt[i]) begin n_fail++; $display("FAIL stats_grant[%0d]: got %0d expected %0d", i, gid, tgt[i]); end
    end
    n_tests++; if (int'(bus.grant_cnt[15:0]) !== e0) begin n_fail++; $display("FAIL stats_ch0: got %0d expected %0d", bus.grant_cnt[15:0], e0); end
    n_tests++; if (int'(bus.grant_cnt[47:32]) !== e2) begin n_fail++; $display("FAIL stats_ch2: got %0d expected %0d", bus.grant_cnt[47:32], e2); end
    n_tests++; if (bus.grant_cnt[31:16] !== 16'h0 || bus.grant_cnt[63:48] !== 16'h0) begin n_fail++; $display("FAIL stats_idle_ch: got %h expected 0", bus.grant_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_data_align();
    test_watchdog();
    test_reset_mid_busy();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
